// File: rtl/sa_output_drain.sv
// rtl/sa_output_drain.sv - deskews per-array systolic results into rows and round-robins them onto one row stream
module sa_output_drain #(
    parameter int N_ARR = 4,
    parameter int COLS  = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_ARR-1:0][COLS-1:0][DW-1:0] sa_output,
    input  logic [N_ARR-1:0][COLS-1:0]         sa_valid_out,
    input  logic [N_ARR-1:0]                   arr_enable,
    output logic [COLS-1:0][DW-1:0]            out_data,
    output logic [$clog2(N_ARR)-1:0]           out_arr,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [N_ARR-1:0]                   overflow,
    output logic                               busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(N_ARR);
    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    logic [DW-1:0]           row_mem  [N_ARR][DEPTH][COLS];
    logic [PW-1:0]           wp       [N_ARR][COLS];
    logic [PW-1:0]           rp       [N_ARR];
    logic [COLS-1:1]         drop_sr  [N_ARR];
    logic [COLS-1:0]         drop_vec [N_ARR];
    logic [N_ARR-1:0]        drop0;
    logic [N_ARR-1:0]        eligible;
    logic [N_ARR-1:0]        pending;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           grant_idx;
    logic                    grant_valid;
    logic                    load_en;
    logic [COLS-1:0][DW-1:0] rd_row;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_ARR) s = s - N_ARR;
        return IW'(s);
    endfunction

    // Bit 0 of drop_vec is this cycle's column-0 decision; bit c replays it c cycles later.
    always_comb begin
        drop0    = '0;
        eligible = '0;
        pending  = '0;
        for (int a = 0; a < N_ARR; a++) begin
            drop0[a]    = arr_enable[a] && sa_valid_out[a][0] && ((wp[a][0] - rp[a]) == FULL);
            drop_vec[a] = {drop_sr[a], drop0[a]};
            eligible[a] = arr_enable[a] && (wp[a][COLS-1] != rp[a]);
            pending[a]  = arr_enable[a] && (wp[a][0] != rp[a]);
        end
    end

    // Descending scan so the array closest after rr_ptr is the last (winning) assignment.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N_ARR - 1; k >= 0; k--) begin
            if (eligible[wrap_add(rr_ptr, k)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        rd_row = '0;
        for (int c = 0; c < COLS; c++) begin
            rd_row[c] = row_mem[grant_idx][rp[grant_idx][AW-1:0]][c];
        end
    end

    assign load_en = !out_valid || out_ready;
    assign busy    = out_valid || (|pending);

    always_ff @(posedge clk) begin
        for (int a = 0; a < N_ARR; a++) begin
            for (int c = 0; c < COLS; c++) begin
                if (arr_enable[a] && sa_valid_out[a][c] && !drop_vec[a][c]) begin
                    row_mem[a][wp[a][c][AW-1:0]][c] <= sa_output[a][c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int a = 0; a < N_ARR; a++) begin
                rp[a]      <= '0;
                drop_sr[a] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    wp[a][c] <= '0;
                end
            end
            overflow  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_arr   <= '0;
            rr_ptr    <= '0;
        end else begin
            for (int a = 0; a < N_ARR; a++) begin
                if (!arr_enable[a]) begin
                    rp[a]       <= '0;
                    drop_sr[a]  <= '0;
                    overflow[a] <= 1'b0;
                    for (int c = 0; c < COLS; c++) begin
                        wp[a][c] <= '0;
                    end
                end else begin
                    for (int c = 0; c < COLS; c++) begin
                        if (sa_valid_out[a][c] && !drop_vec[a][c]) begin
                            wp[a][c] <= wp[a][c] + 1'b1;
                        end
                    end
                    drop_sr[a] <= drop_vec[a][COLS-2:0];
                    if (drop0[a]) begin
                        overflow[a] <= 1'b1;
                    end
                    if (load_en && grant_valid && (grant_idx == IW'(a))) begin
                        rp[a] <= rp[a] + 1'b1;
                    end
                end
            end

            if (load_en) begin
                if (grant_valid) begin
                    out_data  <= rd_row;
                    out_arr   <= grant_idx;
                    out_valid <= 1'b1;
                    rr_ptr    <= wrap_add(grant_idx, 1);
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sa_output_drain.sv
// tb/tb_sa_output_drain.sv - self-checking bench for sa_output_drain with a row-level queue model
module tb_sa_output_drain;
    localparam int N    = 4;
    localparam int C    = 16;
    localparam int DW   = 32;
    localparam int D    = 4;
    localparam int MAXR = 8192;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N-1:0][C-1:0][DW-1:0] sa_output;
    logic [N-1:0][C-1:0]       sa_valid_out;
    logic [N-1:0]              arr_enable;
    logic [C-1:0][DW-1:0]      out_data;
    logic [1:0]                out_arr;
    logic                      out_valid;
    logic                      out_ready;
    logic [N-1:0]              overflow;
    logic                      busy;

    always #5 clk = ~clk;

    sa_output_drain #(.N_ARR(N), .COLS(C), .DW(DW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .sa_output(sa_output), .sa_valid_out(sa_valid_out),
        .arr_enable(arr_enable), .out_data(out_data), .out_arr(out_arr),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nrows  = 0;

    int               hist [N][C];
    int               pend [N];
    logic [C*DW-1:0]  rowdata [MAXR];

    // Row-level reference: a queue of row ids per array, each with the cycle it becomes readable.
    logic             mv;
    logic [C*DW-1:0]  md;
    int               ma;
    logic [N-1:0]     movf;
    int               mrr;
    int               qid  [N][$];
    int               qrdy [N][$];

    int               beats [$];
    logic [C*DW-1:0]  beat_data [$];
    int               beat_cyc [$];

    typedef struct {
        logic [3:0]      mask;
        int              n;
        logic [3:0][1:0] arrs;
    } rr_vec_t;
    rr_vec_t tbl [6];

    task automatic chk(input string name, input logic [C*DW-1:0] act, input logic [C*DW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic queue_row(input int a, input logic [C*DW-1:0] d);
        rowdata[nrows % MAXR] = d;
        pend[a] = nrows % MAXR;
        nrows++;
    endtask

    function automatic logic [C*DW-1:0] rand_row();
        logic [C*DW-1:0] d;
        for (int c = 0; c < C; c++) d[c*DW +: DW] = $urandom;
        return d;
    endfunction

    function automatic bit idle(input int a);
        if (pend[a] >= 0) return 1'b0;
        for (int c = 0; c < C; c++) if (hist[a][c] >= 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_update();
        int pre_sz [N];
        int found;
        int a;
        if (!rst) begin
            mv = 1'b0; md = '0; ma = 0; movf = '0; mrr = 0;
            for (int i = 0; i < N; i++) begin qid[i].delete(); qrdy[i].delete(); end
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (!arr_enable[i]) begin
                qid[i].delete(); qrdy[i].delete(); movf[i] = 1'b0;
            end
            pre_sz[i] = qid[i].size();
        end
        if (!mv || out_ready) begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                a = (mrr + k) % N;
                if (found < 0 && arr_enable[a] && qid[a].size() > 0 && qrdy[a][0] <= cyc) found = a;
            end
            if (found >= 0) begin
                mv = 1'b1;
                md = rowdata[qid[found][0]];
                ma = found;
                void'(qid[found].pop_front());
                void'(qrdy[found].pop_front());
                mrr = (found + 1) % N;
            end else if (out_ready) begin
                mv = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (arr_enable[i] && hist[i][0] >= 0) begin
                if (pre_sz[i] == D) movf[i] = 1'b1;
                else begin
                    qid[i].push_back(hist[i][0]);
                    qrdy[i].push_back(cyc + C);
                end
            end
        end
    endtask

    task automatic compare();
        logic bexp;
        bexp = mv;
        for (int a = 0; a < N; a++) if (arr_enable[a] && qid[a].size() != 0) bexp = 1'b1;
        chk("out_valid", out_valid, mv);
        chk("out_arr", out_arr, ma);
        chk("out_data", out_data, md);
        chk("overflow", overflow, movf);
        chk("busy", busy, bexp);
    endtask

    task automatic step();
        for (int a = 0; a < N; a++) begin
            for (int c = C - 1; c > 0; c--) hist[a][c] = hist[a][c-1];
            hist[a][0] = pend[a];
            pend[a] = -1;
            for (int c = 0; c < C; c++) begin
                sa_valid_out[a][c] = (hist[a][c] >= 0);
                if (hist[a][c] >= 0) sa_output[a][c] = rowdata[hist[a][c]][c*DW +: DW];
                else sa_output[a][c] = '0;
            end
        end
        if (out_valid && out_ready) begin
            beats.push_back(int'(out_arr));
            beat_data.push_back(out_data);
            beat_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        compare();
    endtask

    task automatic clear_beats();
        beats.delete(); beat_data.delete(); beat_cyc.delete();
    endtask

    task automatic chk_beat_row(input string name, input int j, input logic [C*DW-1:0] want);
        logic [C*DW-1:0] got;
        got = '0;
        if (j < beat_data.size()) got = beat_data[j];
        chk(name, got, want);
    endtask

    initial begin
        logic [C*DW-1:0] d;
        int base, first, r0, r5, prob, gap;

        tbl[0] = '{mask: 4'b1111, n: 4, arrs: {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[1] = '{mask: 4'b1111, n: 4, arrs: {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[2] = '{mask: 4'b0100, n: 1, arrs: {2'd0, 2'd0, 2'd0, 2'd2}};
        tbl[3] = '{mask: 4'b1011, n: 3, arrs: {2'd0, 2'd1, 2'd0, 2'd3}};
        tbl[4] = '{mask: 4'b0011, n: 2, arrs: {2'd0, 2'd0, 2'd1, 2'd0}};
        tbl[5] = '{mask: 4'b1000, n: 1, arrs: {2'd0, 2'd0, 2'd0, 2'd3}};

        rst = 1'b0; out_ready = 1'b0; arr_enable = '1; sa_output = '0; sa_valid_out = '0;
        for (int a = 0; a < N; a++) begin
            pend[a] = -1;
            for (int c = 0; c < C; c++) hist[a][c] = -1;
        end
        mv = 1'b0; md = '0; ma = 0; movf = '0; mrr = 0;

        repeat (3) step();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, '0);
        chk("rst_arr", out_arr, 2'd0);
        chk("rst_ovf", overflow, 4'd0);
        chk("rst_busy", busy, 1'b0);

        // single row, column c presented at relative cycle 10+c
        rst = 1'b1; out_ready = 1'b1; base = cyc;
        while (cyc < base + 10) step();
        for (int c = 0; c < C; c++) d[c*DW +: DW] = 32'h100 + c;
        queue_row(0, d);
        first = -1;
        for (int i = 0; i < 40 && first < 0; i++) begin
            step();
            if (out_valid) first = cyc;
        end
        chk("single_latency", first, base + 27);
        chk("single_data", out_data, d);
        chk("single_arr", out_arr, 2'd0);
        chk("single_ovf", overflow, 4'd0);

        rst = 1'b0; repeat (2) step();
        rst = 1'b1; step();

        for (int i = 0; i < 6; i++) begin
            clear_beats();
            for (int a = 0; a < N; a++) if (tbl[i].mask[a]) queue_row(a, rand_row());
            repeat (24) step();
            chk("rr_count", beats.size(), tbl[i].n);
            for (int j = 0; j < tbl[i].n; j++)
                chk("rr_arr", (j < beats.size()) ? beats[j] : 99, tbl[i].arrs[j]);
        end

        // backpressure: four rows on array 1 held behind out_ready = 0
        out_ready = 1'b0; r0 = nrows % MAXR;
        for (int i = 0; i < 4; i++) begin queue_row(1, rand_row()); step(); end
        repeat (20) step();
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_hold", out_data, rowdata[r0]);
        chk("bp_ovf", overflow, 4'd0);
        clear_beats(); out_ready = 1'b1;
        repeat (8) step();
        chk("bp_count", beats.size(), 4);
        for (int j = 0; j < 4; j++) chk_beat_row("bp_row", j, rowdata[r0 + j]);
        gap = (beat_cyc.size() == 4) ? beat_cyc[3] - beat_cyc[0] : -1;
        chk("bp_b2b", gap, 3);

        // overflow: fifth back-to-back row on array 2 is dropped
        out_ready = 1'b0; r0 = nrows % MAXR;
        for (int i = 0; i < 5; i++) begin queue_row(2, rand_row()); step(); end
        repeat (20) step();
        chk("ovf_flag", overflow[2], 1'b1);
        clear_beats(); out_ready = 1'b1;
        repeat (8) step();
        chk("ovf_count", beats.size(), 4);
        for (int j = 0; j < 4; j++) chk_beat_row("ovf_row", j, rowdata[r0 + j]);
        clear_beats(); r5 = nrows % MAXR;
        queue_row(2, rand_row());
        repeat (24) step();
        chk("ovf_row5_count", beats.size(), 1);
        chk_beat_row("ovf_row5", 0, rowdata[r5]);
        chk("ovf_sticky", overflow[2], 1'b1);

        // disable: array 3 loses its two buffered rows, its registered row still drains
        out_ready = 1'b0; clear_beats();
        queue_row(3, rand_row()); step();
        queue_row(3, rand_row()); step();
        queue_row(3, rand_row()); step();
        queue_row(1, rand_row());
        repeat (20) step();
        arr_enable[3] = 1'b0; step(); arr_enable[3] = 1'b1;
        out_ready = 1'b1;
        repeat (8) step();
        chk("dis_count", beats.size(), 2);
        chk("dis_first", (beats.size() > 0) ? beats[0] : 99, 3);
        chk("dis_second", (beats.size() > 1) ? beats[1] : 99, 1);
        chk("dis_ovf3", overflow[3], 1'b0);
        chk("dis_busy", busy, 1'b0);

        // reset with rows buffered and the output register full
        out_ready = 1'b0;
        queue_row(1, rand_row()); queue_row(2, rand_row());
        repeat (20) step();
        chk("rm_pre_valid", out_valid, 1'b1);
        rst = 1'b0; step();
        chk("rm_valid", out_valid, 1'b0);
        chk("rm_data", out_data, '0);
        chk("rm_arr", out_arr, 2'd0);
        chk("rm_ovf", overflow, 4'd0);
        chk("rm_busy", busy, 1'b0);
        rst = 1'b1; repeat (2) step();
        out_ready = 1'b1; base = cyc;
        queue_row(3, rand_row()); queue_row(0, rand_row());
        first = -1;
        for (int i = 0; i < 40 && first < 0; i++) begin
            step();
            if (out_valid) first = cyc;
        end
        chk("rm_latency", first, base + 17);
        chk("rm_first_arr", out_arr, 2'd0);
        repeat (6) step();

        // randomized traffic against the queue model
        for (int blk = 0; blk < 15; blk++) begin
            prob = $urandom_range(20, 95);
            for (int i = 0; i < 200; i++) begin
                out_ready = ($urandom_range(0, 99) < prob);
                for (int a = 0; a < N; a++) begin
                    if (idle(a) && $urandom_range(0, 99) < 2) arr_enable[a] = ~arr_enable[a];
                    if (arr_enable[a] && $urandom_range(0, 99) < 30) queue_row(a, rand_row());
                end
                step();
            end
        end
        out_ready = 1'b1;
        repeat (20) step();
        arr_enable = '1;
        repeat (30) step();
        chk("final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
